// File: rtl/bisr_repair_sequencer.sv
// BIST launch / fault-block filter / BISR load sequencer for the SRAM array.
// One report per distinct 128-byte block; host access held off until repair completes.

module bisr_blk_entry #(
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [IDX_W-1:0] wr_blk,
  input  logic [IDX_W-1:0] cmp_blk,
  output logic             hit
);
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] blk_q, blk_d;

  always_comb begin
    vld_d = vld_q;
    blk_d = blk_q;
    if (clr) begin
      vld_d = 1'b0;
    end else if (wr) begin
      vld_d = 1'b1;
      blk_d = wr_blk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      blk_q <= '0;
    end else begin
      vld_q <= vld_d;
      blk_q <= blk_d;
    end
  end

  assign hit = vld_q && (blk_q == cmp_blk);
endmodule

module bisr_repair_sequencer #(
  parameter int ADDR_W          = 16,
  parameter int BLK_OFS_W       = 7,
  parameter int MAX_FAULT_BLOCK = 25,
  parameter int TIMEOUT_CYCLES  = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BIST_START,
  input  logic              BIST_FAIL_VALID,
  input  logic [ADDR_W-1:0] BIST_FAIL_ADDR,
  input  logic              BIST_DONE,
  output logic              BIST_EN,
  output logic              REPAIR_VALID,
  output logic [ADDR_W-1:0] REPAIR_ADDR,
  output logic [4:0]        FAULT_COUNT,
  output logic              HOST_READY,
  output logic              DONE,
  output logic              UNREPAIRABLE,
  output logic              TIMEOUT
);
  localparam int IDX_W = ADDR_W - BLK_OFS_W;
  localparam int CNT_W = 5;
  localparam int TMO_W = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              unrep_q, unrep_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic              rv_q, rv_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;

  logic [IDX_W-1:0]           fail_blk;
  logic [MAX_FAULT_BLOCK-1:0] hit;
  logic                       accept;
  logic                       list_clr;
  logic                       unused_ofs;

  assign fail_blk   = BIST_FAIL_ADDR[ADDR_W-1:BLK_OFS_W];
  assign unused_ofs = ^BIST_FAIL_ADDR[BLK_OFS_W-1:0];

  // Entry i is only ever written while FAULT_COUNT == i, so the list fills in order.
  for (genvar i = 0; i < MAX_FAULT_BLOCK; i++) begin : g_ent
    bisr_blk_entry #(.IDX_W(IDX_W)) u_ent (
      .clk    (CLK),
      .rst    (RST),
      .clr    (list_clr),
      .wr     (accept && (fault_cnt_q == CNT_W'(i))),
      .wr_blk (fail_blk),
      .cmp_blk(fail_blk),
      .hit    (hit[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    fault_cnt_d = fault_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    unrep_d     = unrep_q;
    tmo_flag_d  = tmo_flag_q;
    rv_d        = 1'b0;
    raddr_d     = raddr_q;
    accept      = 1'b0;
    list_clr    = 1'b0;
    case (state_q)
      S_IDLE: if (START) state_d = S_LAUNCH;
      S_LAUNCH: begin
        list_clr    = 1'b1;
        fault_cnt_d = '0;
        tmo_cnt_d   = '0;
        unrep_d     = 1'b0;
        tmo_flag_d  = 1'b0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (BIST_FAIL_VALID && !(|hit)) begin
          if (fault_cnt_q < CNT_W'(MAX_FAULT_BLOCK)) begin
            accept      = 1'b1;
            fault_cnt_d = fault_cnt_q + CNT_W'(1);
            rv_d        = 1'b1;
            raddr_d     = {fail_blk, {BLK_OFS_W{1'b0}}};
          end else begin
            unrep_d = 1'b1;
          end
        end
        // Done takes priority over an expiring timeout in the same cycle.
        if (BIST_DONE) begin
          state_d = S_DRAIN;
        end else if (tmo_cnt_d == TMO_W'(TIMEOUT_CYCLES)) begin
          tmo_flag_d = 1'b1;
          state_d    = S_FAIL;
        end
      end
      S_DRAIN: state_d = unrep_q ? S_FAIL : S_READY;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      fault_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      unrep_q     <= 1'b0;
      tmo_flag_q  <= 1'b0;
      rv_q        <= 1'b0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      fault_cnt_q <= fault_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      unrep_q     <= unrep_d;
      tmo_flag_q  <= tmo_flag_d;
      rv_q        <= rv_d;
      raddr_q     <= raddr_d;
    end
  end

  assign BIST_START   = (state_q == S_LAUNCH);
  assign BIST_EN      = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign HOST_READY   = (state_q == S_READY);
  assign DONE         = (state_q == S_READY) || (state_q == S_FAIL);
  assign REPAIR_VALID = rv_q;
  assign REPAIR_ADDR  = raddr_q;
  assign FAULT_COUNT  = fault_cnt_q;
  assign UNREPAIRABLE = unrep_q;
  assign TIMEOUT      = tmo_flag_q;
endmodule

// File: tb/tb_bisr_repair_sequencer.sv
// Bench for bisr_repair_sequencer: table-driven runs plus a repair-report scoreboard.

module tb_bisr_repair_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, fv, done_in;
  logic [15:0] faddr;
  logic        bist_start, bist_en, rv, host_ready, done_o, unrep, tmo;
  logic [15:0] raddr;
  logic [4:0]  fcnt;

  logic        t_start;
  logic        t_bist_start, t_bist_en, t_rv, t_host_ready, t_done, t_unrep, t_tmo;
  logic [15:0] t_raddr;
  logic [4:0]  t_fcnt;

  always #5 clk = ~clk;

  bisr_repair_sequencer dut (
    .CLK(clk), .RST(rst), .START(start), .BIST_START(bist_start),
    .BIST_FAIL_VALID(fv), .BIST_FAIL_ADDR(faddr), .BIST_DONE(done_in),
    .BIST_EN(bist_en), .REPAIR_VALID(rv), .REPAIR_ADDR(raddr), .FAULT_COUNT(fcnt),
    .HOST_READY(host_ready), .DONE(done_o), .UNREPAIRABLE(unrep), .TIMEOUT(tmo)
  );

  bisr_repair_sequencer #(.TIMEOUT_CYCLES(50)) dut_tmo (
    .CLK(clk), .RST(rst), .START(t_start), .BIST_START(t_bist_start),
    .BIST_FAIL_VALID(1'b0), .BIST_FAIL_ADDR(16'h0000), .BIST_DONE(1'b0),
    .BIST_EN(t_bist_en), .REPAIR_VALID(t_rv), .REPAIR_ADDR(t_raddr), .FAULT_COUNT(t_fcnt),
    .HOST_READY(t_host_ready), .DONE(t_done), .UNREPAIRABLE(t_unrep), .TIMEOUT(t_tmo)
  );

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        fv;
    logic [15:0] addr;
    logic        done;
    logic [4:0]  exp_cnt;
  } vec_t;

  exp_t        sb[$];
  logic [8:0]  mlist[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: every new block (up to 25) yields a report on the following cycle.
  task automatic model_fail(input logic [15:0] a);
    logic [8:0] b;
    bit         seen;
    b    = a[15:7];
    seen = 1'b0;
    foreach (mlist[k]) if (mlist[k] == b) seen = 1'b1;
    if (!seen && mlist.size() < 25) begin
      mlist.push_back(b);
      sb.push_back('{addr: {b, 7'b0}, cyc: cyc + 1});
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mlist.delete();
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rv) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL report_extra: got REPAIR_VALID addr %h at cycle %0d, expected none", raddr, cyc);
      end else begin
        e = sb.pop_front();
        if (e.addr !== raddr || e.cyc != cyc) begin
          errors++;
          $display("FAIL report: got addr %h cycle %0d expected addr %h cycle %0d", raddr, cyc, e.addr, e.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL report_missing: got no REPAIR_VALID at cycle %0d expected addr %h", cyc, e.addr);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic d);
    fv      = v;
    faddr   = a;
    done_in = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("launch_pulse", {bist_start, bist_en, done_o}, 3'b110);
    tick();
    check("run_entry", {bist_start, bist_en, fcnt}, {2'b01, 5'd0});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    model_reset();
    check("reset_outputs", {bist_start, bist_en, rv, raddr, fcnt, host_ready, done_o, unrep, tmo}, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    vec_t vt[9];
    vt[0] = '{1'b1, 16'h0085, 1'b0, 5'd1};
    vt[1] = '{1'b1, 16'h00F0, 1'b0, 5'd1};
    vt[2] = '{1'b1, 16'h1203, 1'b0, 5'd2};
    vt[3] = '{1'b1, 16'h0001, 1'b0, 5'd3};
    vt[4] = '{1'b0, 16'h0000, 1'b0, 5'd3};
    vt[5] = '{1'b1, 16'h00FE, 1'b0, 5'd3};
    vt[6] = '{1'b1, 16'h2345, 1'b0, 5'd4};
    vt[7] = '{1'b1, 16'h0005, 1'b0, 5'd4};
    vt[8] = '{1'b0, 16'h0000, 1'b1, 5'd4};

    rst = 1'b1; start = 1'b0; t_start = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    do_reset();

    // Fails outside RUN must not be reported.
    drive(1'b1, 16'h0300, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    check("idle_ignores_fail", {fcnt, bist_en}, 6'd0);

    // No faults: done after 100 RUN cycles.
    do_start();
    for (int i = 0; i < 99; i++) tick();
    drive(1'b0, 16'h0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    check("nofault_drain", {bist_en, host_ready, done_o}, 3'b100);
    tick();
    check("nofault_ready", {bist_en, host_ready, done_o, fcnt}, {3'b011, 5'd0});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_ready", {bist_start, bist_en, host_ready}, 3'b001);

    // Dedup table.
    do_reset();
    do_start();
    foreach (vt[i]) begin
      drive(vt[i].fv, vt[i].addr, vt[i].done);
      if (vt[i].fv) model_fail(vt[i].addr);
      tick();
      check($sformatf("dedup_cnt[%0d]", i), fcnt, vt[i].exp_cnt);
    end
    drive(1'b0, 16'h0, 1'b0);
    check("dedup_drain", {bist_en, done_o}, 2'b10);
    tick();
    check("dedup_ready", {host_ready, done_o, unrep}, 3'b110);
    check("repair_addr_hold", raddr, 16'h2300);

    // Fail together with BIST_DONE: reported in DRAIN while BIST_EN is high.
    do_reset();
    do_start();
    tick();
    drive(1'b1, 16'h4000, 1'b1);
    model_fail(16'h4000);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    check("samecyc_drain", {rv, bist_en, raddr}, {2'b11, 16'h4000});
    tick();
    check("samecyc_ready", {host_ready, done_o, fcnt}, {2'b11, 5'd1});

    // Overflow: 26 distinct blocks.
    do_reset();
    do_start();
    for (int i = 0; i < 26; i++) begin
      logic [15:0] a;
      a = 16'(i * 128 + i);
      drive(1'b1, a, 1'b0);
      model_fail(a);
      tick();
      if (i == 24) check("ovf_before", {unrep, fcnt}, {1'b0, 5'd25});
    end
    check("ovf_flag", {unrep, fcnt}, {1'b1, 5'd25});
    drive(1'b1, 16'h0183, 1'b0);
    model_fail(16'h0183);
    tick();
    drive(1'b1, 16'h3200, 1'b1);
    model_fail(16'h3200);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    check("ovf_drain", {bist_en, unrep, done_o}, 3'b110);
    tick();
    check("ovf_fail", {done_o, host_ready, unrep, bist_en, fcnt}, {4'b1010, 5'd25});

    // Asynchronous reset mid-RUN after three reports.
    do_reset();
    do_start();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 16'(i * 16'h0400), 1'b0);
      model_fail(16'(i * 16'h0400));
      tick();
    end
    drive(1'b0, 16'h0, 1'b0);
    tick();
    check("pre_reset_cnt", fcnt, 5'd3);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {bist_start, bist_en, rv, raddr, fcnt, host_ready, done_o, unrep, tmo}, 32'h0);
    do_reset();
    do_start();
    drive(1'b1, 16'h0C00, 1'b0);
    model_fail(16'h0C00);
    tick();
    drive(1'b0, 16'h0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b0);
    check("rerun_cnt", fcnt, 5'd1);
    tick();
    check("rerun_ready", {host_ready, done_o}, 2'b11);

    // Timeout on the 50-cycle instance.
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) tick();
    check("tmo_not_yet", {t_tmo, t_done, t_bist_en}, 3'b001);
    begin
      int n = 0;
      while (!t_done && n < 30) begin
        tick();
        n++;
      end
    end
    check("tmo_fail", {t_tmo, t_done, t_host_ready, t_bist_en}, 4'b1100);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
